// File: rtl/spi_pkg.sv
// Shared FSM state type and SPI mode constants for spi_master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timebase: one-cycle tick every P_CLK_DIV cycles while en is high.
module spi_clk_div #(
    parameter int P_CLK_DIV = 4
) (
    input  logic clk_100,
    input  logic a_rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(P_CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(P_CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            cnt_q <= '0;
        end else if (!en || cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one word per valid/ready handshake, shifted MSB-first on MOSI.
// Receive capture is built only when SPI_RX_EN is defined; otherwise rx_data/rx_valid are tied low.
module spi_master #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CLK_DIV    = 4
) (
    input  logic                    clk_100,
    input  logic                    a_rst_n,
    input  logic                    valid,
    output logic                    ready,
    input  logic [P_DATA_WIDTH-1:0] data,
    output logic                    busy,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    output logic                    spi_cs_n,
    input  logic                    spi_miso,
    output logic [P_DATA_WIDTH-1:0] rx_data,
    output logic                    rx_valid
);

    import spi_pkg::*;

    localparam int BCW = $clog2(P_DATA_WIDTH + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(P_DATA_WIDTH);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

    spi_state_t              state_q, state_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    cs_n_q, cs_n_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [P_DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic                    div_en;
    logic                    tick;
    logic                    lead_edge;
    logic                    trail_edge;
    logic                    sample_edge;
    logic                    done;

    assign div_en = (state_q != IDLE);

    spi_clk_div #(
        .P_CLK_DIV (P_CLK_DIV)
    ) u_clk_div (
        .clk_100 (clk_100),
        .a_rst_n (a_rst_n),
        .en      (div_en),
        .tick    (tick)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        lead_edge  = 1'b0;
        trail_edge = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid && ready_q) begin
                    state_d   = SETUP;
                    cs_n_d    = 1'b0;
                    sclk_d    = SPI_CPOL;
                    mosi_d    = data[P_DATA_WIDTH-1];
                    tx_sh_d   = data;
                    bit_cnt_d = '0;
                end
            end
            SETUP: begin
                // The setup tick doubles as the first leading SCLK edge.
                if (tick) begin
                    state_d   = SHIFT;
                    sclk_d    = ~SPI_CPOL;
                    bit_cnt_d = BIT_ONE;
                    lead_edge = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q != SPI_CPOL) begin
                        sclk_d     = SPI_CPOL;
                        trail_edge = 1'b1;
                        if (bit_cnt_q != BIT_LAST) begin
                            tx_sh_d = tx_sh_q << 1;
                            mosi_d  = tx_sh_q[P_DATA_WIDTH-2];
                        end
                    end else if (bit_cnt_q == BIT_LAST) begin
                        // Last bit's low half-period has elapsed.
                        state_d = HOLD;
                    end else begin
                        sclk_d    = ~SPI_CPOL;
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        lead_edge = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q   <= IDLE;
            sclk_q    <= SPI_CPOL;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Transmit shift register carries no control meaning, so it is not reset.
    always_ff @(posedge clk_100) begin
        tx_sh_q <= tx_sh_d;
    end

    assign sample_edge = (SPI_CPHA == 1'b0) ? lead_edge : trail_edge;

`ifdef SPI_RX_EN
    logic [P_DATA_WIDTH-1:0] rx_sh_q;
    logic [P_DATA_WIDTH-1:0] rx_data_q;
    logic                    rx_valid_q;

    always_ff @(posedge clk_100) begin
        if (sample_edge) begin
            rx_sh_q <= {rx_sh_q[P_DATA_WIDTH-2:0], spi_miso};
        end
    end

    // The received word is published together with chip-select release.
    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= done;
            if (done) begin
                rx_data_q <= rx_sh_q;
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    logic unused_rx;
    assign unused_rx = spi_miso ^ sample_edge ^ done;
    assign rx_data   = '0;
    assign rx_valid  = 1'b0;
`endif

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: scoreboarded frames on a default instance plus a P_CLK_DIV=1 loopback instance.
module tb_spi_master;

    localparam int W      = 8;
    localparam int D      = 4;
    localparam int CS_LOW = (2 * W + 2) * D;
    localparam int CS_LOW1 = (2 * W + 2);

    typedef struct {
        logic [W-1:0] word;
        int           rises;
        int           cs_low;
        int           hi_bad;
        int           lo_bad;
        int           tail;
        logic         ready_up;
        int           gap;
        logic [W-1:0] rxd;
        logic         rxv;
    } frame_t;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic         a_rst_n;
    logic         valid, ready, busy, spi_sclk, spi_mosi, spi_cs_n, spi_miso, rx_valid;
    logic [W-1:0] data, rx_data;
    logic         valid1, ready1, busy1, sclk1, mosi1, cs1, miso1, rx_valid1;
    logic [W-1:0] data1, rx_data1;

    assign spi_miso = spi_mosi;
    assign miso1    = mosi1;

    spi_master #(.P_DATA_WIDTH(W), .P_CLK_DIV(D)) dut (
        .clk_100(clk_100), .a_rst_n(a_rst_n), .valid(valid), .ready(ready), .data(data),
        .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    spi_master #(.P_DATA_WIDTH(W), .P_CLK_DIV(1)) u_div1 (
        .clk_100(clk_100), .a_rst_n(a_rst_n), .valid(valid1), .ready(ready1), .data(data1),
        .busy(busy1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs_n(cs1),
        .spi_miso(miso1), .rx_data(rx_data1), .rx_valid(rx_valid1)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    frame_t       obs_q[$];

    // Frame monitor: written only here, read by the tests.
    logic         m_prev_cs = 1'b1, m_prev_sclk = 1'b0;
    logic [W-1:0] m_cap = '0;
    int           m_rises = 0, m_cs_low = 0, m_hi_bad = 0, m_lo_bad = 0, m_run = 0;
    int           m_gap = 0, m_gap_start = 0, stray_sclk = 0, rxv_count = 0;
    frame_t       m_f;

    always @(negedge clk_100) begin
        if (!a_rst_n) begin
            m_prev_cs   = 1'b1;
            m_prev_sclk = 1'b0;
            m_rises     = 0;
        end else begin
            if (spi_cs_n && spi_sclk) stray_sclk++;
            if (rx_valid) rxv_count++;
            if (m_prev_cs && !spi_cs_n) begin
                m_cap = '0; m_rises = 0; m_cs_low = 0; m_hi_bad = 0; m_lo_bad = 0;
                m_run = 0; m_gap_start = m_gap;
            end
            if (!spi_cs_n) begin
                m_cs_low++;
                if (spi_sclk != m_prev_sclk) begin
                    if (spi_sclk) begin
                        m_cap = {m_cap[W-2:0], spi_mosi};
                        m_rises++;
                        if (m_run != D) m_lo_bad++;
                    end else if (m_run != D) begin
                        m_hi_bad++;
                    end
                    m_run = 1;
                end else begin
                    m_run++;
                end
            end else begin
                m_gap++;
            end
            if (!m_prev_cs && spi_cs_n) begin
                m_f.word = m_cap; m_f.rises = m_rises; m_f.cs_low = m_cs_low;
                m_f.hi_bad = m_hi_bad; m_f.lo_bad = m_lo_bad; m_f.tail = m_run;
                m_f.ready_up = ready; m_f.gap = m_gap_start; m_f.rxd = rx_data; m_f.rxv = rx_valid;
                obs_q.push_back(m_f);
                m_gap = 1;
            end
            m_prev_cs   = spi_cs_n;
            m_prev_sclk = spi_sclk;
        end
    end

    // Offers a word with valid held high until accepted; call at a negedge.
    task automatic offer(input logic [W-1:0] d, output bit ok);
        valid = 1'b1;
        data  = d;
        ok    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_100);
        end
        if (ok) begin
            exp_q.push_back(d);
            @(negedge clk_100);
        end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_100);
        end
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; valid = 1'b0; data = '0; valid1 = 1'b0; data1 = '0;
        repeat (3) @(negedge clk_100);
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== '0) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if ({cs1, sclk1, ready1, busy1} !== 4'b1000) begin failures++; $display("FAIL reset_div1 got=%b exp=1000", {cs1, sclk1, ready1, busy1}); end
        a_rst_n = 1'b1;
        @(negedge clk_100);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        offer(8'hA5, ok);
        valid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL single_handshake got=timeout exp=accepted"); end
        checks++; if ({spi_cs_n, ready, busy} !== 3'b001) begin failures++; $display("FAIL single_start got=%b exp=001", {spi_cs_n, ready, busy}); end
        wait_obs(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_frame got=timeout exp=frame"); end
        if (ok && exp_q.size() > 0) begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (f.word !== e) begin failures++; $display("FAIL single_word got=%h exp=%h", f.word, e); end
            checks++; if (f.rises != W) begin failures++; $display("FAIL single_rises got=%0d exp=%0d", f.rises, W); end
            checks++; if (f.cs_low != CS_LOW) begin failures++; $display("FAIL single_cs_low got=%0d exp=%0d", f.cs_low, CS_LOW); end
            checks++; if (f.hi_bad != 0) begin failures++; $display("FAIL single_high_width got=%0d bad exp=0", f.hi_bad); end
            checks++; if (f.lo_bad != 0) begin failures++; $display("FAIL single_low_width got=%0d bad exp=0", f.lo_bad); end
            checks++; if (f.tail != 2 * D) begin failures++; $display("FAIL single_tail got=%0d exp=%0d", f.tail, 2 * D); end
            checks++; if (f.ready_up !== 1'b1) begin failures++; $display("FAIL single_ready_at_cs_rise got=%b exp=1", f.ready_up); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok;
        frame_t f;
        logic [W-1:0] e;
        offer(8'h01, ok1);
        offer(8'h80, ok2);
        valid = 1'b0;
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL b2b_handshake got=%b%b exp=11", ok1, ok2); end
        wait_obs(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_frames got=%0d exp=2", obs_q.size()); end
        for (int k = 0; k < 2; k++) begin
            if (obs_q.size() > 0 && exp_q.size() > 0) begin
                f = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++; if (f.word !== e) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", k, f.word, e); end
                checks++; if (f.cs_low != CS_LOW) begin failures++; $display("FAIL b2b_cs_low%0d got=%0d exp=%0d", k, f.cs_low, CS_LOW); end
                if (k == 1) begin
                    checks++; if (f.gap != 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=1", f.gap); end
                end
            end
        end
        repeat (2 * CS_LOW) @(negedge clk_100);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra_frames got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_flow_control();
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        offer(8'h55, ok);
        valid = 1'b0;
        repeat (20) @(negedge clk_100);
        valid = 1'b1;
        data  = 8'h3C;
        checks++; if ({ready, busy} !== 2'b01) begin failures++; $display("FAIL flow_busy got=%b exp=01", {ready, busy}); end
        offer(8'h3C, ok);
        valid = 1'b0;
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL flow_accept_order got=%0d exp=1", obs_q.size()); end
        wait_obs(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL flow_frames got=%0d exp=2", obs_q.size()); end
        for (int k = 0; k < 2; k++) begin
            if (obs_q.size() > 0 && exp_q.size() > 0) begin
                f = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++; if (f.word !== e) begin failures++; $display("FAIL flow_word%0d got=%h exp=%h", k, f.word, e); end
            end
        end
        repeat (2 * CS_LOW) @(negedge clk_100);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL flow_duplicate got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int stray0, rxv0;
        stray0 = stray_sclk;
        rxv0   = rxv_count;
        offer(8'hF0, ok);
        valid = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_rises >= 3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_100);
        end
        checks++; if (!seen) begin failures++; $display("FAIL mid_third_rise got=timeout exp=seen"); end
        #2 a_rst_n = 1'b0;
        #1;
        checks++; if ({spi_cs_n, spi_sclk, ready, busy} !== 4'b1000) begin failures++; $display("FAIL mid_async_outputs got=%b exp=1000", {spi_cs_n, spi_sclk, ready, busy}); end
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (3) @(negedge clk_100);
        #2 a_rst_n = 1'b1;
        repeat (2 * CS_LOW) @(negedge clk_100);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL mid_residual_frame got=%0d exp=0", obs_q.size()); end
        checks++; if (stray_sclk != stray0) begin failures++; $display("FAIL mid_residual_sclk got=%0d exp=%0d", stray_sclk, stray0); end
        checks++; if (rxv_count != rxv0) begin failures++; $display("FAIL mid_rx_valid got=%0d exp=%0d", rxv_count, rxv0); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", ready); end
    endtask

    task automatic test_div1_loopback();
        bit ok, done;
        int low, rises, pulses;
        logic prev_s, rxv_at;
        logic [W-1:0] cap, rxd_at, exp_rx;
        int exp_pulses;
        valid1 = 1'b1;
        data1  = 8'hC3;
        ok     = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ready1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_100);
        end
        @(negedge clk_100);
        valid1 = 1'b0;
        data1  = '0;
        checks++; if (!ok) begin failures++; $display("FAIL div1_handshake got=timeout exp=accepted"); end
        low = 0; rises = 0; pulses = 0; prev_s = 1'b0; cap = '0; done = 1'b0; rxv_at = 1'b0; rxd_at = '0;
        for (int i = 0; i < 60; i++) begin
            if (!cs1) low++;
            if (sclk1 && !prev_s) begin
                cap = {cap[W-2:0], mosi1};
                rises++;
            end
            if (rx_valid1) pulses++;
            if (cs1 && low > 0) begin
                done = 1'b1; rxv_at = rx_valid1; rxd_at = rx_data1;
                break;
            end
            prev_s = sclk1;
            @(negedge clk_100);
        end
        repeat (10) begin
            @(negedge clk_100);
            if (rx_valid1) pulses++;
        end
`ifdef SPI_RX_EN
        exp_rx = 8'hC3; exp_pulses = 1;
`else
        exp_rx = 8'h00; exp_pulses = 0;
`endif
        checks++; if (!done) begin failures++; $display("FAIL div1_frame got=timeout exp=frame"); end
        checks++; if (low != CS_LOW1) begin failures++; $display("FAIL div1_cs_low got=%0d exp=%0d", low, CS_LOW1); end
        checks++; if (rises != W) begin failures++; $display("FAIL div1_rises got=%0d exp=%0d", rises, W); end
        checks++; if (cap !== 8'hC3) begin failures++; $display("FAIL div1_word got=%h exp=c3", cap); end
        checks++; if (rxd_at !== exp_rx) begin failures++; $display("FAIL div1_rx_data got=%h exp=%h", rxd_at, exp_rx); end
        checks++; if (rxv_at !== (exp_pulses == 1)) begin failures++; $display("FAIL div1_rx_valid_at_cs_rise got=%b exp=%0d", rxv_at, exp_pulses); end
        checks++; if (pulses != exp_pulses) begin failures++; $display("FAIL div1_rx_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_reset_mid();
        test_div1_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master transmitter/receiver sitting directly downstream of the test-word source. It accepts one `P_DATA_WIDTH`-bit word per valid/ready handshake and shifts it out MSB-first on MOSI with a generated SCLK and an active-low chip select. Optionally it captures MISO into a parallel receive word. All outputs are registered and run on the single system clock.

## Interface
- `P_DATA_WIDTH`, 8: word length in bits; must be ≥ 2.
- `P_CLK_DIV`, 4: SCLK half-period in `clk_100` cycles; must be ≥ 1.
- `clk_100` in 1: system clock; all logic is on its rising edge.
- `a_rst_n` in 1: reset, asynchronous, active-low.
- `valid` in 1: upstream word available.
- `ready` out 1: block can accept a word.
- `data` in `P_DATA_WIDTH`: word to transmit; sampled in the handshake cycle.
- `busy` out 1: a transfer is in progress (any state other than IDLE).
- `spi_sclk` out 1: serial clock; idles low.
- `spi_mosi` out 1: serial data out.
- `spi_cs_n` out 1: chip select, active-low.
- `spi_miso` in 1: serial data in.
- `rx_data` out `P_DATA_WIDTH`: last received word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on `valid && ready`.
  - SETUP → SHIFT after `P_CLK_DIV` cycles.
  - SHIFT → HOLD after the `P_DATA_WIDTH`-th falling SCLK edge.
  - HOLD → IDLE after `P_CLK_DIV` cycles.
- `ready`: 1 only in IDLE, and 0 while `a_rst_n` is low. `busy` is `!ready` outside reset.
- Handshake cycle: `data` is loaded into the shift register and the first half-period starts.
- SETUP:
  - `spi_cs_n` goes 0.
  - `spi_mosi` is set to MSB.
  - `spi_sclk` is 0.
- SHIFT:
  - `spi_sclk` toggles every `P_CLK_DIV` cycles, starting with a rise. There are exactly `P_DATA_WIDTH` rising edges.
  - On each falling edge except the last, the shift register shifts left and `spi_mosi` takes the next bit.
  - The slave samples on rising edges.
- HOLD: `spi_sclk` is 0 and `spi_cs_n` stays 0. On exit `spi_cs_n` goes 1.
- `valid` while busy is ignored. Upstream holds it, and no word is lost or duplicated.
- Counters:
  - Divider counter is `$clog2(P_CLK_DIV+1)` bits wide and counts 0..`P_CLK_DIV`-1, then wraps.
  - Bit counter is `$clog2(P_DATA_WIDTH+1)` bits wide and counts rising edges; it is compared with `P_DATA_WIDTH`.
- Reset mid-transfer:
  - All outputs immediately take their reset values.
  - The word in flight is discarded and `rx_valid` does not pulse.
- Reset values:
  - `spi_cs_n`=1.
  - `spi_sclk`=0, `spi_mosi`=0.
  - `ready`=0, `busy`=0.
  - `rx_data`=0, `rx_valid`=0.

## Timing
- Handshake at cycle T. `spi_cs_n` falls at T+1.
- `spi_cs_n` stays low for exactly `(2*P_DATA_WIDTH+2)*P_CLK_DIV` cycles (72 for the defaults).
- First SCLK rise is at T+1+`P_CLK_DIV`.
- `ready` rises in the same cycle `spi_cs_n` rises. A handshake in that cycle gives `spi_cs_n` high for exactly 1 cycle.
- Back-to-back word period is `(2*P_DATA_WIDTH+2)*P_CLK_DIV + 1` cycles.
- `P_CLK_DIV`=1 is legal: SCLK runs at `clk_100`/2.

## Configuration
- Macro: `SPI_RX_EN`.
- Defined:
  - `spi_miso` is sampled on each rising SCLK edge, in the same cycle `spi_sclk` goes 1, into a receive shift register MSB-first.
  - `rx_data` updates and `rx_valid` pulses for 1 cycle in the cycle `spi_cs_n` rises.
- Undefined:
  - No receive logic is built.
  - `rx_data` is tied to 0, `rx_valid` is tied to 0, and `spi_miso` is unused.
  - The port list is identical in both builds.

## Structure
- `spi_pkg` holds:
  - the state enum typedef `spi_state_t` {IDLE, SETUP, SHIFT, HOLD};
  - the SPI mode constants (CPOL=0, CPHA=0).
- One sub-module, `spi_clk_div`. Parameter `P_CLK_DIV`. Ports: `clk_100`, `a_rst_n`, `en`. It emits a one-cycle `tick` every `P_CLK_DIV` cycles while `en` is high, and clears its counter when `en` is low.

## Test plan
- Reset check: hold `a_rst_n`=0 → `spi_cs_n`=1, `spi_sclk`=0, `ready`=0, `rx_valid`=0. Release → `ready`=1 on the next edge.
- Single word 0xA5, defaults:
  - `spi_mosi` at the 8 rising edges reads 1,0,1,0,0,1,0,1.
  - `spi_cs_n` is low for 72 cycles, with 8 SCLK pulses, each 4 cycles high and 4 low.
- Back-to-back: `valid` held high with 0x01 then 0x80 → `spi_cs_n` high for exactly 1 cycle between words. Both words are serialised correctly with no third transfer.
- Flow control: assert `valid` with 0x3C mid-transfer → `ready`=0 and there is no handshake until IDLE. 0x3C is sent exactly once afterwards.
- Reset mid-transfer: assert `a_rst_n`=0 after the 3rd rising edge → `spi_cs_n`=1 asynchronously. After release there is no residual SCLK and no `rx_valid`.
- With `SPI_RX_EN`, `P_CLK_DIV`=1, loopback `spi_miso`=`spi_mosi`, send 0xC3 → `rx_data`=0xC3 and `rx_valid` pulses once, in the cycle `spi_cs_n` rises.
